// File: rtl/alu_pkg.sv
// Shared definitions for the multi-operation ALU: op codes, flag bit
// positions, multiplier state encodings and a flag-packing helper.
package alu_pkg;

    // Operation codes
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    // Bit positions inside the {C,Z,N,V} flag word
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    // Sequential multiplier states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mul_state_e;

    // Assemble the four condition bits into the flag-register layout.
    function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                              input logic n, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: operands are captured on start, one partial
// product is accumulated per cycle for WIDTH cycles, then the full product is
// published and held until the next completed multiply or reset.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_e           state_r, state_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [WIDTH-1:0]     mcand_r, mcand_s;
    // Upper half accumulates partial sums, lower half holds the remaining
    // multiplier bits; the whole thing shifts right once per step.
    logic [2*WIDTH-1:0]   acc_r, acc_s;
    logic [2*WIDTH-1:0]   product_r, product_s;
    logic                 busy_r, busy_s;
    logic [WIDTH:0]       partial_s;

    // Next-state, datapath and busy decode for the multiplier.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        mcand_s   = mcand_r;
        acc_s     = acc_r;
        product_s = product_r;
        busy_s    = 1'b0;
        if (acc_r[0]) begin
            partial_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            partial_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mcand_s = a;
                    acc_s   = {{WIDTH{1'b0}}, b};
                    cnt_s   = CW'(WIDTH);
                    state_s = ST_RUN;
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            ST_RUN: begin
                acc_s = {partial_s, acc_r[WIDTH-1:1]};
                cnt_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    product_s = {partial_s, acc_r[WIDTH-1:1]};
                    state_s   = ST_IDLE;
                    busy_s    = 1'b0;
                end else begin
                    busy_s    = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Multiplier state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            mcand_r   <= mcand_s;
            acc_r     <= acc_s;
            product_r <= product_s;
            busy_r    <= busy_s;
        end
    end

    assign busy    = busy_r;
    assign product = product_r;

endmodule

// File: rtl/multi_op_alu.sv
// Multi-operation ALU on the shared tri-state bus: NUM_REGS bus-loadable
// operand registers, an 8-op combinational ALU, a latched {C,Z,N,V} flag
// register and, when ALU_MUL_EN is defined, a sequential multiplier.
// Without ALU_MUL_EN the multiplier is not built, busy reads 0, start is
// ignored and op 7 evaluates to zero.
module multi_op_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int NUM_REGS = 4,
    localparam int RSEL     = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             li,
    input  logic [RSEL-1:0]  ld_sel,
    input  logic             ro,
    input  logic [RSEL-1:0]  out_sel,
    input  logic [RSEL-1:0]  a_sel,
    input  logic [RSEL-1:0]  b_sel,
    input  logic [2:0]       op,
    input  logic             eo,
    input  logic             fi,
    input  logic             start,
    output logic             busy,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] regs_r [NUM_REGS];
    logic [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             ovf_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] mul_lo_s, mul_hi_s;
    logic [WIDTH-1:0] drive_s;
    logic [3:0]       flags_r;
    logic [3:0]       flags_s;

    assign a_s = regs_r[a_sel];
    assign b_s = regs_r[b_sel];

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] product_s;

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_s),
        .b       (b_s),
        .busy    (busy),
        .product (product_s)
    );

    assign mul_lo_s = product_s[WIDTH-1:0];
    assign mul_hi_s = product_s[2*WIDTH-1:WIDTH];
`else
    logic start_unused_s;

    assign start_unused_s = start;
    assign busy           = 1'b0;
    assign mul_lo_s       = {WIDTH{1'b0}};
    assign mul_hi_s       = {WIDTH{1'b0}};
`endif

    // ALU result, carry and signed-overflow selection.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        sum_s    = {(WIDTH+1){1'b0}};
        case (op)
            OP_ADD: begin
                sum_s    = {1'b0, a_s} + {1'b0, b_s};
                result_s = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = (a_s[WIDTH-1] == b_s[WIDTH-1]) &&
                           (result_s[WIDTH-1] != a_s[WIDTH-1]);
            end
            OP_SUB: begin
                // carry set means no borrow occurred
                sum_s    = {1'b0, a_s} + {1'b0, ~b_s} + {{WIDTH{1'b0}}, 1'b1};
                result_s = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = (a_s[WIDTH-1] != b_s[WIDTH-1]) &&
                           (result_s[WIDTH-1] != a_s[WIDTH-1]);
            end
            OP_AND: result_s = a_s & b_s;
            OP_OR:  result_s = a_s | b_s;
            OP_XOR: result_s = a_s ^ b_s;
            OP_SHL: begin
                result_s = {a_s[WIDTH-2:0], 1'b0};
                carry_s  = a_s[WIDTH-1];
            end
            OP_SHR: begin
                result_s = {1'b0, a_s[WIDTH-1:1]};
                carry_s  = a_s[0];
            end
            OP_MUL: begin
                result_s = mul_lo_s;
                carry_s  = |mul_hi_s;
            end
            default: begin
                result_s = {WIDTH{1'b0}};
                carry_s  = 1'b0;
            end
        endcase
    end

    assign flags_s = pack_flags(carry_s, ~|result_s, result_s[WIDTH-1], ovf_s);

    // Bus source: the ALU result takes priority over a register read-out.
    always_comb begin
        drive_s = regs_r[out_sel];
        if (eo) begin
            drive_s = result_s;
        end else begin
            drive_s = regs_r[out_sel];
        end
    end

    assign bus = (eo || ro) ? drive_s : {WIDTH{1'bz}};

    // Operand register file, loaded from the bus.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (li) begin
            regs_r[ld_sel] <= bus;
        end else begin
            regs_r[ld_sel] <= regs_r[ld_sel];
        end
    end

    // Flag register, updated only when fi is asserted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flags_r <= 4'b0000;
        end else if (fi) begin
            flags_r <= flags_s;
        end else begin
            flags_r <= flags_r;
        end
    end

    assign flags = flags_r;

endmodule

// File: tb/tb_multi_op_alu.sv
// Directed self-checking bench for multi_op_alu. Expected values are queued
// as stimulus is applied and compared when the DUT output is sampled.
module tb_multi_op_alu;

    localparam int WIDTH    = 8;
    localparam int NUM_REGS = 4;

    logic             clk;
    logic             rst;
    wire  [WIDTH-1:0] bus;
    logic             li, ro, eo, fi, start;
    logic [1:0]       ld_sel, out_sel, a_sel, b_sel;
    logic [2:0]       op;
    logic             busy;
    logic [3:0]       flags;

    logic [WIDTH-1:0] tb_data;
    logic             tb_en;

    logic [15:0] exp_q [$];
    int          n_vec;
    int          n_err;

    assign bus = tb_en ? tb_data : {WIDTH{1'bz}};

    multi_op_alu #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .li      (li),
        .ld_sel  (ld_sel),
        .ro      (ro),
        .out_sel (out_sel),
        .a_sel   (a_sel),
        .b_sel   (b_sel),
        .op      (op),
        .eo      (eo),
        .fi      (fi),
        .start   (start),
        .busy    (busy),
        .flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_err++;
                $display("FAIL %s: observed %h expected %h", tag, obs, exp);
                $error("miscompare on %s", tag);
            end
        end
    endtask

    task automatic load_reg(input int idx, input logic [7:0] val);
        tb_data = val;
        tb_en   = 1'b1;
        ld_sel  = idx[1:0];
        li      = 1'b1;
        tick();
        li      = 1'b0;
        tb_en   = 1'b0;
    endtask

    // Apply an op with eo, check the bus, then latch flags and check them.
    task automatic op_check(input string tag, input logic [2:0] o, input int as,
                            input int bs, input logic [7:0] exp_bus,
                            input logic [3:0] exp_flags);
        op    = o;
        a_sel = as[1:0];
        b_sel = bs[1:0];
        eo    = 1'b1;
        exp_q.push_back({8'h00, exp_bus});
        #1;
        check({tag, "_bus"}, {8'h00, bus});
        exp_q.push_back({12'h000, exp_flags});
        fi = 1'b1;
        tick();
        fi = 1'b0;
        eo = 1'b0;
        check({tag, "_flags"}, {12'h000, flags});
    endtask

    initial begin
        int n;
        n_vec = 0; n_err = 0;
        rst = 1'b0; li = 1'b0; ro = 1'b0; eo = 1'b0; fi = 1'b0; start = 1'b0;
        ld_sel = 2'd0; out_sel = 2'd0; a_sel = 2'd0; b_sel = 2'd0; op = 3'd0;
        tb_data = 8'h00; tb_en = 1'b0;

        // Reset, with loads/fi/start requested in the same cycle
        li = 1'b1; fi = 1'b1; start = 1'b1;
        tb_en = 1'b1; tb_data = 8'hA5;
        tick();
        rst = 1'b1; li = 1'b0; fi = 1'b0; start = 1'b0; tb_en = 1'b0;
        exp_q.push_back(16'h0000);
        check("reset_flags", {12'h000, flags});
        exp_q.push_back(16'h0000);
        check("reset_busy", {15'h0000, busy});
        for (int i = 0; i < NUM_REGS; i++) begin
            ro = 1'b1; out_sel = i[1:0];
            exp_q.push_back(16'h0000);
            #1;
            check("reset_reg", {8'h00, bus});
        end
        ro = 1'b0;
        op_check("zero_add", 3'd0, 0, 0, 8'h00, 4'b0100);

        // ADD with signed overflow, bus idle while nothing drives it
        load_reg(0, 8'h7F);
        load_reg(1, 8'h01);
        op = 3'd0; a_sel = 2'd0; b_sel = 2'd1;
        tb_en = 1'b1; tb_data = 8'h00;
        exp_q.push_back(16'h0000);
        #1;
        check("idle_bus", {8'h00, bus});
        tb_en = 1'b0;
        op_check("add_ovf", 3'd0, 0, 1, 8'h80, 4'b0011);

        // SUB equal operands
        load_reg(0, 8'h05);
        load_reg(1, 8'h05);
        op_check("sub_eq", 3'd1, 0, 1, 8'h00, 4'b1100);

        // Logic and shifts
        load_reg(0, 8'h81);
        op_check("shl", 3'd5, 0, 1, 8'h02, 4'b1000);
        op_check("shr", 3'd6, 0, 1, 8'h40, 4'b1000);
        load_reg(1, 8'hFF);
        op_check("xor", 3'd4, 0, 1, 8'h7E, 4'b0000);
        op_check("and", 3'd2, 0, 1, 8'h81, 4'b0010);
        op_check("or",  3'd3, 0, 1, 8'hFF, 4'b0010);
        load_reg(2, 8'h00);
        op_check("sub_borrow", 3'd1, 2, 0, 8'h7F, 4'b0000);

        // eo and ro together: ALU result wins
        op = 3'd4; a_sel = 2'd0; b_sel = 2'd1;
        eo = 1'b1; ro = 1'b1; out_sel = 2'd1;
        exp_q.push_back(16'h007E);
        #1;
        check("eo_priority", {8'h00, bus});
        eo = 1'b0; ro = 1'b0;

        // Read-out and load of the same register in one cycle
        load_reg(2, 8'h3C);
        ro = 1'b1; out_sel = 2'd2; li = 1'b1; ld_sel = 2'd2;
        exp_q.push_back(16'h003C);
        #1;
        check("same_reg_old", {8'h00, bus});
        tick();
        li = 1'b0;
        exp_q.push_back(16'h003C);
        check("same_reg_new", {8'h00, bus});
        // Register copy reg1 -> reg2 across the bus
        out_sel = 2'd1; li = 1'b1; ld_sel = 2'd2;
        tick();
        li = 1'b0; out_sel = 2'd2;
        exp_q.push_back(16'h00FF);
        #1;
        check("reg_copy", {8'h00, bus});
        ro = 1'b0;

`ifdef ALU_MUL_EN
        // 0x10 * 0x20 = 0x0200
        load_reg(0, 8'h10);
        load_reg(1, 8'h20);
        a_sel = 2'd0; b_sel = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(16'h0001);
        check("busy_rise", {15'h0000, busy});
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        exp_q.push_back(16'd8);
        check("busy_len", n[15:0]);
        op_check("mul_hi", 3'd7, 0, 1, 8'h00, 4'b1100);

        // 0x0F * 0x0F = 0x00E1 with operand reload and a stray start mid-run
        load_reg(0, 8'h0F);
        load_reg(1, 8'h0F);
        start = 1'b1;
        tick();
        start = 1'b0;
        load_reg(0, 8'h01);
        start = 1'b1;
        tick();
        start = 1'b0;
        op = 3'd7; fi = 1'b1;
        tick();
        fi = 1'b0;
        exp_q.push_back(16'h000C);
        check("fi_busy_flags", {12'h000, flags});
        n = 3;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        exp_q.push_back(16'd8);
        check("busy_len2", n[15:0]);
        op_check("mul_e1", 3'd7, 0, 1, 8'hE1, 4'b0010);

        // Abort by reset mid-run
        load_reg(0, 8'h03);
        load_reg(1, 8'h03);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.push_back(16'h0000);
        check("abort_busy", {15'h0000, busy});
        load_reg(0, 8'h03);
        load_reg(1, 8'h03);
        tick();
        tick();
        op_check("abort_mul", 3'd7, 0, 1, 8'h00, 4'b0100);
`else
        load_reg(0, 8'h10);
        load_reg(1, 8'h20);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(16'h0000);
        check("nomul_busy", {15'h0000, busy});
        tick();
        op_check("nomul_op7", 3'd7, 0, 1, 8'h00, 4'b0100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
